lcd_driver: RTL and testbench

- RGB-parallel LCD timing generator. Produces HSYNC/VSYNC/DE and drives the panel RGB bus.
- Issues pixel_xpos/pixel_ypos one cycle ahead of DE. A registered pixel source (e.g. the image-processing display block) returns pixel_data exactly in time for DE.
- Timing set is selected at run time from the panel ID. The selected resolution is exported as h_disp/v_disp.

---
 rtl/lcd_timing_pkg.sv | 94 +++++++++
 rtl/lcd_timing_lut.sv | 31 +++
 rtl/lcd_driver.sv | 110 +++++++++++
 tb/tb_lcd_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_pkg
// Description : Panel IDs, per-mode RGB LCD timing constants, coordinate width
//               and the ID-to-mode decode shared by the LCD driver files.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_timing_pkg;

  localparam int COORD_W = 11;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;

  typedef enum logic [1:0] {
    MODE_4342 = 2'd0,
    MODE_7084 = 2'd1,
    MODE_7016 = 2'd2
  } lcd_mode_t;

  typedef struct packed {
    logic [COORD_W-1:0] h_sync;
    logic [COORD_W-1:0] h_back;
    logic [COORD_W-1:0] h_disp;
    logic [COORD_W-1:0] h_front;
    logic [COORD_W-1:0] h_total;
    logic [COORD_W-1:0] v_sync;
    logic [COORD_W-1:0] v_back;
    logic [COORD_W-1:0] v_disp;
    logic [COORD_W-1:0] v_front;
    logic [COORD_W-1:0] v_total;
  } lcd_timing_t;

  // 480x272
  localparam logic [COORD_W-1:0] H_SYNC_4342  = 11'd41;
  localparam logic [COORD_W-1:0] H_BACK_4342  = 11'd2;
  localparam logic [COORD_W-1:0] H_DISP_4342  = 11'd480;
  localparam logic [COORD_W-1:0] H_FRONT_4342 = 11'd2;
  localparam logic [COORD_W-1:0] H_TOTAL_4342 = 11'd525;
  localparam logic [COORD_W-1:0] V_SYNC_4342  = 11'd10;
  localparam logic [COORD_W-1:0] V_BACK_4342  = 11'd2;
  localparam logic [COORD_W-1:0] V_DISP_4342  = 11'd272;
  localparam logic [COORD_W-1:0] V_FRONT_4342 = 11'd2;
  localparam logic [COORD_W-1:0] V_TOTAL_4342 = 11'd286;

  // 800x480
  localparam logic [COORD_W-1:0] H_SYNC_7084  = 11'd128;
  localparam logic [COORD_W-1:0] H_BACK_7084  = 11'd88;
  localparam logic [COORD_W-1:0] H_DISP_7084  = 11'd800;
  localparam logic [COORD_W-1:0] H_FRONT_7084 = 11'd40;
  localparam logic [COORD_W-1:0] H_TOTAL_7084 = 11'd1056;
  localparam logic [COORD_W-1:0] V_SYNC_7084  = 11'd2;
  localparam logic [COORD_W-1:0] V_BACK_7084  = 11'd33;
  localparam logic [COORD_W-1:0] V_DISP_7084  = 11'd480;
  localparam logic [COORD_W-1:0] V_FRONT_7084 = 11'd10;
  localparam logic [COORD_W-1:0] V_TOTAL_7084 = 11'd525;

  // 1024x600
  localparam logic [COORD_W-1:0] H_SYNC_7016  = 11'd20;
  localparam logic [COORD_W-1:0] H_BACK_7016  = 11'd140;
  localparam logic [COORD_W-1:0] H_DISP_7016  = 11'd1024;
  localparam logic [COORD_W-1:0] H_FRONT_7016 = 11'd160;
  localparam logic [COORD_W-1:0] H_TOTAL_7016 = 11'd1344;
  localparam logic [COORD_W-1:0] V_SYNC_7016  = 11'd3;
  localparam logic [COORD_W-1:0] V_BACK_7016  = 11'd20;
  localparam logic [COORD_W-1:0] V_DISP_7016  = 11'd600;
  localparam logic [COORD_W-1:0] V_FRONT_7016 = 11'd12;
  localparam logic [COORD_W-1:0] V_TOTAL_7016 = 11'd635;

  localparam lcd_timing_t T_4342 = '{H_SYNC_4342, H_BACK_4342, H_DISP_4342,
                                     H_FRONT_4342, H_TOTAL_4342, V_SYNC_4342,
                                     V_BACK_4342, V_DISP_4342, V_FRONT_4342,
                                     V_TOTAL_4342};
  localparam lcd_timing_t T_7084 = '{H_SYNC_7084, H_BACK_7084, H_DISP_7084,
                                     H_FRONT_7084, H_TOTAL_7084, V_SYNC_7084,
                                     V_BACK_7084, V_DISP_7084, V_FRONT_7084,
                                     V_TOTAL_7084};
  localparam lcd_timing_t T_7016 = '{H_SYNC_7016, H_BACK_7016, H_DISP_7016,
                                     H_FRONT_7016, H_TOTAL_7016, V_SYNC_7016,
                                     V_BACK_7016, V_DISP_7016, V_FRONT_7016,
                                     V_TOTAL_7016};

  // Unknown panel IDs fall back to the smallest (480x272) timing set.
  function automatic lcd_mode_t mode_from_id(input logic [15:0] id);
    case (id)
      ID_7084: mode_from_id = MODE_7084;
      ID_7016: mode_from_id = MODE_7016;
      default: mode_from_id = MODE_4342;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timing_lut.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_lut
// Description : Combinational lookup from the latched panel mode to its full
//               timing set, plus the active resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_lut
  import lcd_timing_pkg::*;
(
  input  lcd_mode_t          mode,
  output lcd_timing_t        timing,
  output logic [COORD_W-1:0] h_disp,
  output logic [COORD_W-1:0] v_disp
);

  // Select the timing set for the latched mode.
  always_comb begin
    timing = T_4342;
    case (mode)
      MODE_7084: timing = T_7084;
      MODE_7016: timing = T_7016;
      default:   timing = T_4342;
    endcase
  end

  assign h_disp = timing.h_disp;
  assign v_disp = timing.v_disp;

endmodule
`default_nettype wire

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_driver
// Description : RGB-parallel LCD timing generator. Counts pixels/lines,
//               latches the panel mode at frame boundaries, and decodes
//               HSYNC/VSYNC/DE plus a one-cycle-early pixel request.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_driver
  import lcd_timing_pkg::*;
(
  input  logic               lcd_pclk,
  input  logic               rst,
  input  logic [15:0]        lcd_id,
  input  logic [23:0]        pixel_data,
  output logic [COORD_W-1:0] pixel_xpos,
  output logic [COORD_W-1:0] pixel_ypos,
  output logic [COORD_W-1:0] h_disp,
  output logic [COORD_W-1:0] v_disp,
  output logic               lcd_hs,
  output logic               lcd_vs,
  output logic               lcd_de,
  output logic [23:0]        lcd_rgb,
  output logic               lcd_bl,
  output logic               frame_start
);

  lcd_mode_t          r_mode;
  lcd_timing_t        w_t;
  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic               w_h_last;
  logic               w_v_last;
  logic [COORD_W-1:0] w_h_start;
  logic [COORD_W-1:0] w_h_end;
  logic [COORD_W-1:0] w_v_start;
  logic [COORD_W-1:0] w_v_end;
  logic               w_h_act;
  logic               w_h_req;
  logic               w_v_act;
  logic               w_unused_front;

  lcd_timing_lut u_lut (
    .mode   (r_mode),
    .timing (w_t),
    .h_disp (h_disp),
    .v_disp (v_disp)
  );

  // Front porches are already folded into the totals.
  assign w_unused_front = ^{w_t.h_front, w_t.v_front};

  assign w_h_last  = (r_h_cnt == w_t.h_total - 11'd1);
  assign w_v_last  = (r_v_cnt == w_t.v_total - 11'd1);
  assign w_h_start = w_t.h_sync + w_t.h_back;
  assign w_h_end   = w_h_start + w_t.h_disp;
  assign w_v_start = w_t.v_sync + w_t.v_back;
  assign w_v_end   = w_v_start + w_t.v_disp;

  // Mode only changes on reset or the last cycle of a frame, so a frame
  // always runs to completion with a single timing set.
  always_ff @(posedge lcd_pclk) begin
    if (rst || (w_h_last && w_v_last)) begin
      r_mode <= mode_from_id(lcd_id);
    end
  end

  // Pixel and line counters; both wrap together at frame end.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // Backlight turns on once reset is released.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      lcd_bl <= 1'b0;
    end else begin
      lcd_bl <= 1'b1;
    end
  end

  // Sync/DE decode; the request window leads DE by one cycle so a registered
  // pixel source lines up with DE.
  always_comb begin
    w_h_act     = (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end);
    w_h_req     = (r_h_cnt >= w_h_start - 11'd1) && (r_h_cnt < w_h_end - 11'd1);
    w_v_act     = (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);
    lcd_hs      = (r_h_cnt >= w_t.h_sync);
    lcd_vs      = (r_v_cnt >= w_t.v_sync);
    lcd_de      = w_h_act && w_v_act;
    lcd_rgb     = lcd_de ? pixel_data : 24'h0;
    frame_start = (r_h_cnt == '0) && (r_v_cnt == '0) && !rst;
    pixel_xpos  = '0;
    pixel_ypos  = '0;
    if (w_h_req && w_v_act) begin
      pixel_xpos = r_h_cnt - (w_h_start - 11'd1);
      pixel_ypos = r_v_cnt - w_v_start;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_driver
// Description : Self-checking bench for lcd_driver: table of reset/ID vectors,
//               frame-position reference model compared every cycle, and
//               hand sequences for line counts and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lcd_id = 16'h4342;
  logic [23:0] pixel_data = 24'h0;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
  logic [23:0] lcd_rgb;

  logic        fill_en  = 1'b0;
  logic [23:0] fill_val = 24'h0;

  int n_checks = 0;
  int n_err    = 0;

  lcd_driver dut (
    .lcd_pclk    (clk),
    .rst         (rst),
    .lcd_id      (lcd_id),
    .pixel_data  (pixel_data),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .h_disp      (h_disp),
    .v_disp      (v_disp),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .lcd_bl      (lcd_bl),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Registered pixel source: answers the requested coordinate one cycle later,
  // or a constant fill pattern.
  always @(posedge clk) begin
    pixel_data <= fill_en ? fill_val : {13'h0, pixel_xpos};
  end

  // ---------------- reference model (frame position based) ----------------
  typedef struct {
    int hs, hb, hd, hf, vs, vb, vd, vf;
  } tm_t;

  function automatic tm_t lookup(input logic [15:0] id);
    tm_t t;
    case (id)
      16'h7084: t = '{128, 88, 800, 40, 2, 33, 480, 10};
      16'h7016: t = '{20, 140, 1024, 160, 3, 20, 600, 12};
      default:  t = '{41, 2, 480, 2, 10, 2, 272, 2};
    endcase
    return t;
  endfunction

  tm_t         m;
  int          p = 0;      // cycle index within the current frame
  int          h = 0, v = 0;
  int          ht = 0, vt = 0;
  int          exp_x = 0;
  logic [23:0] exp_pd = 24'h0;
  logic        exp_bl = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", nm, act, exp, h, v, $time);
    end
  endtask

  task automatic tick();
    int x_st, y_st;
    logic de, req, v_in;
    @(posedge clk);
    exp_pd = fill_en ? fill_val : {13'h0, exp_x[10:0]};
    if (rst) begin
      p = 0;
      m = lookup(lcd_id);
      exp_bl = 1'b0;
    end else begin
      if (p == ht * vt - 1) begin
        p = 0;
        m = lookup(lcd_id);
      end else begin
        p++;
      end
      exp_bl = 1'b1;
    end
    ht = m.hs + m.hb + m.hd + m.hf;
    vt = m.vs + m.vb + m.vd + m.vf;
    #1;
    h = p % ht;
    v = p / ht;
    x_st = m.hs + m.hb;
    y_st = m.vs + m.vb;
    v_in = (v >= y_st) && (v < y_st + m.vd);
    de   = (h >= x_st) && (h < x_st + m.hd) && v_in;
    req  = (h >= x_st - 1) && (h < x_st + m.hd - 1) && v_in;
    exp_x = req ? h - (x_st - 1) : 0;
    chk("hs", lcd_hs, h >= m.hs);
    chk("vs", lcd_vs, v >= m.vs);
    chk("de", lcd_de, de);
    chk("xpos", pixel_xpos, exp_x);
    chk("ypos", pixel_ypos, req ? v - y_st : 0);
    chk("rgb", lcd_rgb, de ? exp_pd : 24'h0);
    chk("bl", lcd_bl, exp_bl);
    chk("frame_start", frame_start, (p == 0) && !rst);
    chk("h_disp", h_disp, m.hd);
    chk("v_disp", v_disp, m.vd);
  endtask

  // Hold reset for n cycles with the given ID, then release.
  task automatic do_reset(input logic [15:0] id, input int n);
    rst = 1'b1;
    lcd_id = id;
    for (int i = 0; i < n; i++) tick();
    chk("rst_de", lcd_de, 0);
    chk("rst_rgb", lcd_rgb, 0);
    chk("rst_bl", lcd_bl, 0);
    rst = 1'b0;
    #1;
    chk("frame_start_release", frame_start, 1);
    tick();
    chk("bl_after_release", lcd_bl, 1);
  endtask

  typedef struct {
    logic [15:0] id;
    int          hd;
    int          vd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int de_cnt, hs_low;
    vecs[0] = '{16'h4342, 480, 272};
    vecs[1] = '{16'h7084, 800, 480};
    vecs[2] = '{16'h7016, 1024, 600};
    vecs[3] = '{16'h1234, 480, 272};
    vecs[4] = '{16'h0000, 480, 272};

    // Reset decode table.
    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].id, (i == 0) ? 5 : 2);
      chk("tbl_h_disp", h_disp, vecs[i].hd);
      chk("tbl_v_disp", v_disp, vecs[i].vd);
    end

    // 4342 with ramp data and random mid-frame ID changes.
    fill_en = 1'b0;
    do_reset(16'h4342, 5);
    de_cnt = 0;
    hs_low = 0;
    for (int c = 0; c < 14 * 525; c++) begin
      tick();
      if (v == 12 && lcd_de) de_cnt++;
      if (v == 1 && !lcd_hs) hs_low++;
      if (c == 1000) lcd_id = 16'h7084;
      else if ($urandom_range(499) == 0) begin
        case ($urandom_range(3))
          0: lcd_id = 16'h4342;
          1: lcd_id = 16'h7084;
          2: lcd_id = 16'h7016;
          default: lcd_id = 16'($urandom);
        endcase
      end
    end
    chk("de_count_line12", de_cnt, 480);
    chk("hs_low_line1", hs_low, 41);

    // 7084 with a random fill pattern.
    fill_en = 1'b1;
    fill_val = 24'($urandom);
    do_reset(16'h7084, 2);
    hs_low = 0;
    for (int c = 0; c < 3 * 1056; c++) begin
      tick();
      if (v == 1 && !lcd_hs) hs_low++;
    end
    chk("hs_low_7084", hs_low, 128);

    // 7016 with white fill, reset pulsed inside the active area.
    fill_val = 24'hFFFFFF;
    do_reset(16'h7016, 2);
    de_cnt = 0;
    for (int c = 0; c < 24 * 1344 + 700 - 1; c++) begin
      tick();
      if (v == 23 && lcd_de) de_cnt++;
    end
    chk("de_count_7016", de_cnt, 1024);
    chk("rgb_active_fill", lcd_rgb, 24'hFFFFFF);
    rst = 1'b1;
    tick();
    chk("midrst_xpos", pixel_xpos, 0);
    chk("midrst_de", lcd_de, 0);
    chk("midrst_rgb", lcd_rgb, 0);
    chk("midrst_bl", lcd_bl, 0);
    rst = 1'b0;
    #1;
    chk("midrst_frame_start", frame_start, 1);
    de_cnt = 0;
    for (int c = 0; c < 2 * 1344; c++) begin
      tick();
      if (lcd_de) de_cnt++;
    end
    chk("no_spurious_de", de_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
